rs_issue: RTL and testbench

RS_ISSUE -- requirements
Module: rs_issue

---
 rtl/rs_issue_pkg.sv | 64 ++++++
 rtl/rs_issue_select.sv | 41 ++++
 rtl/rs_issue.sv | 113 +++++++++++
 tb/tb_rs_issue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_pkg.sv
// Shared reservation-station types: entry layout, CDB broadcast, bank size and
// the operand wakeup helper used by both the bank and the allocation bypass.
package rs_issue_pkg;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(RS_SIZE);

  typedef logic [DATA_W-1:0] MemoryWord;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_e;

  typedef struct packed {
    fu_e        fu;
    logic [3:0] op;
    logic       mem_rd;
    logic       mem_wr;
  } control_bits;

  typedef struct packed {
    logic        busy;
    control_bits ctrl_bits;
    tag_t        tag;
    tag_t        tag_1;
    tag_t        tag_2;
    MemoryWord   value_1;
    MemoryWord   value_2;
    MemoryWord   imm;
  } rs_entry;

  typedef struct packed {
    tag_t      tag;
    MemoryWord value;
  } cdb;

  // Capture a broadcast value into any operand still waiting on its tag; cdb1 wins ties.
  function automatic rs_entry rs_wakeup(rs_entry e, cdb c1, cdb c2);
    rs_entry r;
    r = e;
    if (e.tag_1 != '0 && e.tag_1 == c1.tag) begin
      r.value_1 = c1.value;
      r.tag_1   = '0;
    end else if (e.tag_1 != '0 && e.tag_1 == c2.tag) begin
      r.value_1 = c2.value;
      r.tag_1   = '0;
    end
    if (e.tag_2 != '0 && e.tag_2 == c1.tag) begin
      r.value_2 = c1.value;
      r.tag_2   = '0;
    end else if (e.tag_2 != '0 && e.tag_2 == c2.tag) begin
      r.value_2 = c2.value;
      r.tag_2   = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_issue_select.sv
// Ready-slot picker: lowest index by default, oldest by allocation order when
// RS_AGE_SELECT_EN is defined (age[i][j]=1 means slot i is older than slot j).
module rs_select
  import rs_issue_pkg::*;
(
  input  logic [RS_SIZE-1:0]              i_ready,
`ifdef RS_AGE_SELECT_EN
  input  logic [RS_SIZE-1:0][RS_SIZE-1:0] i_age,
`endif
  output logic [RS_SIZE-1:0]              o_grant,
  output logic [IDX_W-1:0]                o_idx,
  output logic                            o_found
);

  logic [RS_SIZE-1:0] w_grant;

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_grant
`ifdef RS_AGE_SELECT_EN
    localparam logic [RS_SIZE-1:0] SELF = RS_SIZE'(1) << gi;
    // Win only if older than every other ready slot.
    assign w_grant[gi] = i_ready[gi] && (&(i_age[gi] | ~i_ready | SELF));
`else
    if (gi == 0) begin : g_first
      assign w_grant[gi] = i_ready[gi];
    end else begin : g_rest
      assign w_grant[gi] = i_ready[gi] && !(|i_ready[gi-1:0]);
    end
`endif
  end

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_grant[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_grant = w_grant;
  assign o_found = |i_ready;

endmodule

// File: rtl/rs_issue.sv
// Reservation station bank with CDB wakeup and a single registered issue port.
// Optional feature macro: RS_AGE_SELECT_EN (oldest-first select via age matrix).
module rs_issue
  import rs_issue_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    alloc_valid,
  input  rs_entry alloc_entry,
  input  int      alloc_id,
  input  cdb      cdb1,
  input  cdb      cdb2,
  input  logic    flush,
  input  logic    issue_ready,
  output logic    issue_valid,
  output rs_entry issue_entry,
  output int      issue_id,
  output rs_entry res_stations [RS_SIZE],
  output logic    rs_full
);

  rs_entry            r_rs [RS_SIZE];
  logic               r_issue_valid;
  rs_entry            r_issue_entry;
  logic [IDX_W-1:0]   r_issue_id;

  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_alloc_hit;
  logic [RS_SIZE-1:0] w_grant;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_found;
  logic               w_clear;
  logic               w_issue_load;
  rs_entry            w_alloc_woken;

  assign w_clear       = reset | flush;
  assign w_issue_load  = !r_issue_valid || issue_ready;
  assign w_alloc_woken = rs_wakeup(alloc_entry, cdb1, cdb2);

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_slot
    assign w_busy[gi]      = r_rs[gi].busy;
    assign w_ready[gi]     = r_rs[gi].busy && r_rs[gi].tag_1 == '0 && r_rs[gi].tag_2 == '0;
    assign w_alloc_hit[gi] = alloc_valid && !r_rs[gi].busy && (alloc_id == gi);
  end

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] r_age;

  // A new allocation becomes younger than every other slot.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          if (i != j) begin
            if (w_alloc_hit[i])      r_age[i][j] <= 1'b0;
            else if (w_alloc_hit[j]) r_age[i][j] <= 1'b1;
          end
        end
      end
    end
  end
`endif

  rs_select u_select (
    .i_ready (w_ready),
`ifdef RS_AGE_SELECT_EN
    .i_age   (r_age),
`endif
    .o_grant (w_grant),
    .o_idx   (w_sel_idx),
    .o_found (w_found)
  );

  // Alloc and issue are exclusive per slot: alloc needs busy=0, issue needs busy=1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_clear) begin
        r_rs[i] <= '0;
      end else if (w_alloc_hit[i]) begin
        r_rs[i]      <= w_alloc_woken;
        r_rs[i].busy <= 1'b1;
      end else if (w_issue_load && w_found && w_grant[i]) begin
        r_rs[i].busy <= 1'b0;
      end else if (r_rs[i].busy) begin
        r_rs[i] <= rs_wakeup(r_rs[i], cdb1, cdb2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_issue_valid <= 1'b0;
      r_issue_entry <= '0;
      r_issue_id    <= '0;
    end else if (w_issue_load) begin
      r_issue_valid <= w_found;
      if (w_found) begin
        r_issue_entry <= r_rs[w_sel_idx];
        r_issue_id    <= w_sel_idx;
      end
    end
  end

  assign issue_valid  = r_issue_valid;
  assign issue_entry  = r_issue_entry;
  assign issue_id     = int'(r_issue_id);
  assign res_stations = r_rs;
  assign rs_full      = &w_busy;

endmodule

// File: tb/tb_rs_issue.sv
// Directed bench for rs_issue: a per-cycle vector table plus hand sequences for
// back-pressure hold, bank full, flush and mid-operation reset.
module tb_rs_issue;
  import rs_issue_pkg::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    alloc_valid;
  rs_entry alloc_entry;
  int      alloc_id;
  cdb      cdb1;
  cdb      cdb2;
  logic    flush;
  logic    issue_ready;
  logic    issue_valid;
  rs_entry issue_entry;
  int      issue_id;
  rs_entry res_stations [RS_SIZE];
  logic    rs_full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rs_issue dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_entry  (alloc_entry),
    .alloc_id     (alloc_id),
    .cdb1         (cdb1),
    .cdb2         (cdb2),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .issue_valid  (issue_valid),
    .issue_entry  (issue_entry),
    .issue_id     (issue_id),
    .res_stations (res_stations),
    .rs_full      (rs_full)
  );

  typedef struct {
    logic               av;
    rs_entry            ae;
    int                 aid;
    cdb                 c1;
    cdb                 c2;
    logic               ir;
    logic               ev;
    int                 eid;
    MemoryWord          ev1;
    MemoryWord          ev2;
    logic [RS_SIZE-1:0] ebusy;
    int                 cs;
    tag_t               ct1;
    tag_t               ct2;
    MemoryWord          cv1;
    MemoryWord          cv2;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rs_entry mk(tag_t t, tag_t t1, tag_t t2, MemoryWord v1, MemoryWord v2);
    rs_entry e;
    e           = '0;
    e.busy      = 1'b1;
    e.ctrl_bits.op = 4'h3;
    e.tag       = t;
    e.tag_1     = t1;
    e.tag_2     = t2;
    e.value_1   = v1;
    e.value_2   = v2;
    return e;
  endfunction

  function automatic cdb mkc(tag_t t, MemoryWord v);
    cdb c;
    c.tag   = t;
    c.value = v;
    return c;
  endfunction

  function automatic vec_t mkv(logic av, rs_entry ae, int aid, cdb c1, cdb c2, logic ir,
                               logic ev, int eid, MemoryWord ev1, MemoryWord ev2,
                               logic [RS_SIZE-1:0] ebusy, int cs, tag_t ct1, tag_t ct2,
                               MemoryWord cv1, MemoryWord cv2);
    vec_t v;
    v.av = av; v.ae = ae; v.aid = aid; v.c1 = c1; v.c2 = c2; v.ir = ir;
    v.ev = ev; v.eid = eid; v.ev1 = ev1; v.ev2 = ev2; v.ebusy = ebusy;
    v.cs = cs; v.ct1 = ct1; v.ct2 = ct2; v.cv1 = cv1; v.cv2 = cv2;
    return v;
  endfunction

  function automatic logic [RS_SIZE-1:0] busy_mask();
    logic [RS_SIZE-1:0] m;
    for (int i = 0; i < RS_SIZE; i++) m[i] = res_stations[i].busy;
    return m;
  endfunction

  task automatic idle();
    reset       = 1'b0;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_entry = '0;
    alloc_id    = 0;
    cdb1        = '0;
    cdb2        = '0;
    issue_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int id, input rs_entry e);
    alloc_valid = 1'b1;
    alloc_id    = id;
    alloc_entry = e;
  endtask

  initial begin
    rs_entry ea, eb, ec;
    int first_id, second_id;
    cdb nc;
    nc = '0;

    vecs[0] = mkv(1, mk(3, 0, 0, 5, 7),    0, nc, nc, 1, 0, 0, 0,     0,     8'b0000_0001, -1, 0, 0, 0, 0);
    vecs[1] = mkv(0, '0,                   0, nc, nc, 1, 1, 0, 5,     7,     8'b0000_0000,  0, 0, 0, 5, 7);
    vecs[2] = mkv(1, mk(8, 4, 0, 0, 9),    1, nc, nc, 1, 0, 0, 0,     0,     8'b0000_0010,  1, 4, 0, 0, 9);
    vecs[3] = mkv(0, '0,                   0, nc, nc, 1, 0, 0, 0,     0,     8'b0000_0010, -1, 0, 0, 0, 0);
    vecs[4] = mkv(0, '0,                   0, nc, mkc(4, 32'h55), 1, 0, 0, 0, 0, 8'b0000_0010, 1, 0, 0, 32'h55, 9);
    vecs[5] = mkv(0, '0,                   0, nc, nc, 1, 1, 1, 32'h55, 9,    8'b0000_0000, -1, 0, 0, 0, 0);
    vecs[6] = mkv(1, mk(9, 0, 6, 1, 0),    3, mkc(6, 32'h66), mkc(6, 32'h77), 1, 0, 0, 0, 0, 8'b0000_1000, 3, 0, 0, 1, 32'h66);
    vecs[7] = mkv(0, '0,                   0, nc, nc, 1, 1, 3, 1,     32'h66, 8'b0000_0000, -1, 0, 0, 0, 0);
    vecs[8] = mkv(1, mk(2, 0, 0, 1, 1), RS_SIZE, nc, nc, 1, 0, 0, 0,  0,     8'b0000_0000, -1, 0, 0, 0, 0);

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset.issue_valid", 64'(issue_valid), 64'd0);
    chk("reset.issue_id", 64'(issue_id), 64'd0);
    chk("reset.issue_entry", 64'(issue_entry.value_1 | issue_entry.value_2), 64'd0);
    chk("reset.busy", 64'(busy_mask()), 64'd0);
    chk("reset.rs_full", 64'(rs_full), 64'd0);
    $display("[TB] reset done valid=%0b busy=%b", issue_valid, busy_mask());

    for (int k = 0; k < 9; k++) begin
      alloc_valid = vecs[k].av;
      alloc_entry = vecs[k].ae;
      alloc_id    = vecs[k].aid;
      cdb1        = vecs[k].c1;
      cdb2        = vecs[k].c2;
      issue_ready = vecs[k].ir;
      tick();
      idle();
      $display("[TB] vec %0d valid=%0b id=%0d v1=0x%0h v2=0x%0h busy=%b",
               k, issue_valid, issue_id, issue_entry.value_1, issue_entry.value_2, busy_mask());
      chk($sformatf("vec%0d.issue_valid", k), 64'(issue_valid), 64'(vecs[k].ev));
      if (vecs[k].ev) begin
        chk($sformatf("vec%0d.issue_id", k), 64'(issue_id), 64'(vecs[k].eid));
        chk($sformatf("vec%0d.value_1", k), 64'(issue_entry.value_1), 64'(vecs[k].ev1));
        chk($sformatf("vec%0d.value_2", k), 64'(issue_entry.value_2), 64'(vecs[k].ev2));
        chk($sformatf("vec%0d.tags", k), 64'({issue_entry.tag_1, issue_entry.tag_2}), 64'd0);
      end
      chk($sformatf("vec%0d.busy", k), 64'(busy_mask()), 64'(vecs[k].ebusy));
      if (vecs[k].cs >= 0) begin
        chk($sformatf("vec%0d.slot_tags", k),
            64'({res_stations[vecs[k].cs].tag_1, res_stations[vecs[k].cs].tag_2}),
            64'({vecs[k].ct1, vecs[k].ct2}));
        chk($sformatf("vec%0d.slot_v1", k), 64'(res_stations[vecs[k].cs].value_1), 64'(vecs[k].cv1));
        chk($sformatf("vec%0d.slot_v2", k), 64'(res_stations[vecs[k].cs].value_2), 64'(vecs[k].cv2));
      end
    end

    // Back-pressure: slot 0 occupies the issue register while 5 then 2 become ready.
    ea = mk(1, 0, 0, 32'h11, 32'h12);
    eb = mk(5, 0, 0, 32'h50, 32'h51);
    ec = mk(2, 0, 0, 32'h20, 32'h21);
    idle(); issue_ready = 1'b0; do_alloc(0, ea); tick();
    idle(); issue_ready = 1'b0; do_alloc(5, eb); tick();
    chk("hold.first_issue_id", 64'(issue_id), 64'd0);
    chk("hold.busy_e2", 64'(busy_mask()), 64'b0010_0000);
    idle(); issue_ready = 1'b0; do_alloc(2, ec); tick();
    chk("hold.busy_e3", 64'(busy_mask()), 64'b0010_0100);
    for (int c = 0; c < 3; c++) begin
      idle(); issue_ready = 1'b0; tick();
      $display("[TB] hold cycle %0d valid=%0b id=%0d v1=0x%0h", c, issue_valid, issue_id, issue_entry.value_1);
      chk($sformatf("hold%0d.valid", c), 64'(issue_valid), 64'd1);
      chk($sformatf("hold%0d.id", c), 64'(issue_id), 64'd0);
      chk($sformatf("hold%0d.value_1", c), 64'(issue_entry.value_1), 64'h11);
    end
`ifdef RS_AGE_SELECT_EN
    first_id = 5; second_id = 2;
`else
    first_id = 2; second_id = 5;
`endif
    idle(); tick();
    $display("[TB] release valid=%0b id=%0d", issue_valid, issue_id);
    chk("release.first_id", 64'(issue_id), 64'(first_id));
    chk("release.first_v1", 64'(issue_entry.value_1), (first_id == 5) ? 64'h50 : 64'h20);
    idle(); tick();
    $display("[TB] release2 valid=%0b id=%0d", issue_valid, issue_id);
    chk("release.second_id", 64'(issue_id), 64'(second_id));
    idle(); tick();
    chk("release.drained", 64'(issue_valid), 64'd0);

    // Fill every slot with entries that wait on tag 7 so nothing issues.
    for (int i = 0; i < RS_SIZE; i++) begin
      idle(); issue_ready = 1'b0; do_alloc(i, mk(tag_t'(8'h20 + i), 7, 0, MemoryWord'(i), 0)); tick();
      $display("[TB] fill slot %0d busy=%b full=%0b", i, busy_mask(), rs_full);
      chk($sformatf("fill%0d.rs_full", i), 64'(rs_full), (i == RS_SIZE - 1) ? 64'd1 : 64'd0);
    end
    idle(); issue_ready = 1'b0; do_alloc(4, mk(6'h3F, 0, 0, 32'hAA, 32'hBB)); tick();
    $display("[TB] alloc to busy slot 4 tag=0x%0h v1=0x%0h", res_stations[4].tag, res_stations[4].value_1);
    chk("full.slot4_tag", 64'(res_stations[4].tag), 64'h24);
    chk("full.slot4_v1", 64'(res_stations[4].value_1), 64'd4);
    chk("full.slot4_t1", 64'(res_stations[4].tag_1), 64'd7);
    chk("full.no_issue", 64'(issue_valid), 64'd0);

    idle(); flush = 1'b1; tick();
    chk("flush1.busy", 64'(busy_mask()), 64'd0);

    // Flush with four busy slots, a live issue and a concurrent alloc.
    for (int i = 0; i < 5; i++) begin
      idle(); issue_ready = 1'b0; do_alloc(i, mk(tag_t'(8'h30 + i), 0, 0, MemoryWord'(i), MemoryWord'(i))); tick();
    end
    $display("[TB] pre-flush valid=%0b busy=%b", issue_valid, busy_mask());
    chk("preflush.valid", 64'(issue_valid), 64'd1);
    chk("preflush.busy", 64'(busy_mask()), 64'b0001_1110);
    idle(); flush = 1'b1; issue_ready = 1'b1; do_alloc(6, mk(9, 0, 0, 1, 2)); tick();
    $display("[TB] flush valid=%0b busy=%b full=%0b", issue_valid, busy_mask(), rs_full);
    chk("flush2.busy", 64'(busy_mask()), 64'd0);
    chk("flush2.valid", 64'(issue_valid), 64'd0);
    chk("flush2.rs_full", 64'(rs_full), 64'd0);

    // Reset mid-operation discards the in-flight ready entry.
    idle(); do_alloc(0, mk(4, 0, 0, 3, 3)); tick();
    idle(); reset = 1'b1; do_alloc(1, mk(5, 0, 0, 4, 4)); tick();
    idle(); tick();
    $display("[TB] mid-reset valid=%0b busy=%b", issue_valid, busy_mask());
    chk("midreset.valid", 64'(issue_valid), 64'd0);
    chk("midreset.busy", 64'(busy_mask()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
